fp32_div_seq: RTL and testbench

//  Iterative IEEE-754 single-precision divider (data1 / data2), the inverse companion to the combinational FPU multiplier.

---
 rtl/fpu_pkg.sv | 29 ++
 rtl/fp_div_step.sv | 18 +
 rtl/fp32_div_seq.sv | 204 ++++++++++++++++++++
 tb/tb_fp32_div_seq.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared single-precision FPU types and constants
package fpu_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } fp32_t;

  typedef struct packed {
    logic invalid;
    logic div_by_zero;
    logic overflow;
    logic underflow;
  } fp_flags_t;

  localparam logic [31:0] FP32_QNAN    = 32'h7FC00000;
  localparam logic [7:0]  FP32_EXP_MAX = 8'hFF;
  localparam int          FP32_BIAS    = 127;

  typedef enum logic [2:0] {
    IDLE,
    CLASSIFY,
    DIVIDE,
    ROUND,
    DONE
  } div_state_e;

endpackage

// File: rtl/fp_div_step.sv
// rtl/fp_div_step.sv - one radix-2 restoring division step
// rem < 2*mb on entry, so the post-subtract value always fits in 24 bits.
module fp_div_step (
  input  logic [24:0] rem,
  input  logic [23:0] mb,
  output logic [24:0] rem_next,
  output logic        qbit
);

  logic [23:0] diff;

  always_comb begin
    qbit     = (rem >= {1'b0, mb});
    diff     = qbit ? 24'(rem - {1'b0, mb}) : rem[23:0];
    rem_next = {diff, 1'b0};
  end

endmodule

// File: rtl/fp32_div_seq.sv
// rtl/fp32_div_seq.sv - iterative IEEE-754 single-precision divider (data1 / data2)
// Define FP_DIV_ROUND_EN for round-to-nearest-even; otherwise the quotient is truncated.
module fp32_div_seq
  import fpu_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1,
  parameter int EXP_BIAS       = FP32_BIAS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow,
  output logic        div_by_zero,
  output logic        invalid
);

  localparam int NUM_ITER = 26 / BITS_PER_CYCLE;

`ifdef FP_DIV_ROUND_EN
  localparam logic ROUND_EN = 1'b1;
`else
  localparam logic ROUND_EN = 1'b0;
`endif

  div_state_e        state_q, state_d;
  fp32_t             a_q, a_d, b_q, b_d;
  logic [24:0]       rem_q, rem_d;
  logic [25:0]       quo_q, quo_d;
  logic [4:0]        cnt_q, cnt_d;
  logic signed [9:0] exp_q, exp_d;
  logic [31:0]       result_q, result_d;
  fp_flags_t         flags_q, flags_d;

  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sgn, special;
  logic [31:0] spec_res;
  fp_flags_t   spec_flags;

  // Denormals have exp=0 and are treated as zero, keeping their sign.
  always_comb begin
    a_zero     = (a_q.exp == 8'd0);
    b_zero     = (b_q.exp == 8'd0);
    a_inf      = (a_q.exp == FP32_EXP_MAX) && (a_q.mant == 23'd0);
    b_inf      = (b_q.exp == FP32_EXP_MAX) && (b_q.mant == 23'd0);
    a_nan      = (a_q.exp == FP32_EXP_MAX) && (a_q.mant != 23'd0);
    b_nan      = (b_q.exp == FP32_EXP_MAX) && (b_q.mant != 23'd0);
    sgn        = a_q.sign ^ b_q.sign;
    special    = 1'b1;
    spec_res   = '0;
    spec_flags = '0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_res           = FP32_QNAN;
      spec_flags.invalid = 1'b1;
    end else if (a_inf) begin
      spec_res = {sgn, FP32_EXP_MAX, 23'd0};
    end else if (b_zero) begin
      spec_res               = {sgn, FP32_EXP_MAX, 23'd0};
      spec_flags.div_by_zero = 1'b1;
    end else if (a_zero || b_inf) begin
      spec_res = {sgn, 31'd0};
    end else begin
      special = 1'b0;
    end
  end

  logic [23:0]               mb;
  logic [24:0]               rem_chain [0:BITS_PER_CYCLE];
  logic [BITS_PER_CYCLE-1:0] qbits;

  assign mb           = {1'b1, b_q.mant};
  assign rem_chain[0] = rem_q;

  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
    fp_div_step u_step (
      .rem      (rem_chain[i]),
      .mb       (mb),
      .rem_next (rem_chain[i+1]),
      .qbit     (qbits[BITS_PER_CYCLE-1-i])
    );
  end

  logic [24:0]       quo_n;
  logic signed [9:0] exp_n, exp_r;
  logic              guard, sticky, rnd_inc;
  logic [23:0]       mant_sum;
  logic [31:0]       norm_res;
  fp_flags_t         norm_flags;

  // Quotient lies in (0.5, 2): at most one left shift normalises it.
  always_comb begin
    if (quo_q[25]) begin
      quo_n = quo_q[24:0];
      exp_n = exp_q;
    end else begin
      quo_n = {quo_q[23:0], 1'b0};
      exp_n = exp_q - 10'sd1;
    end
    guard      = quo_n[1];
    sticky     = quo_n[0] | (|rem_q);
    rnd_inc    = ROUND_EN & guard & (sticky | quo_n[2]);
    mant_sum   = {1'b0, quo_n[24:2]} + {23'd0, rnd_inc};
    exp_r      = exp_n + 10'(mant_sum[23]);
    norm_flags = '0;
    norm_res   = {sgn, exp_r[7:0], mant_sum[22:0]};
    if (exp_r >= 10'sd255) begin
      norm_res            = {sgn, FP32_EXP_MAX, 23'd0};
      norm_flags.overflow = 1'b1;
    end else if (exp_r <= 10'sd0) begin
      norm_res             = {sgn, 31'd0};
      norm_flags.underflow = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    exp_d    = exp_q;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = data1;
          b_d     = data2;
          state_d = CLASSIFY;
        end
      end
      CLASSIFY: begin
        if (special) begin
          // Specials still pass through ROUND so their latency is two cycles.
          state_d = ROUND;
        end else begin
          rem_d   = {2'b01, a_q.mant};
          quo_d   = '0;
          cnt_d   = '0;
          exp_d   = 10'(a_q.exp) - 10'(b_q.exp) + 10'(EXP_BIAS);
          state_d = DIVIDE;
        end
      end
      DIVIDE: begin
        rem_d = rem_chain[BITS_PER_CYCLE];
        quo_d = {quo_q[25-BITS_PER_CYCLE:0], qbits};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(NUM_ITER - 1)) begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        result_d = special ? spec_res : norm_res;
        flags_d  = special ? spec_flags : norm_flags;
        state_d  = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      exp_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      exp_q    <= exp_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign result      = result_q;
  assign overflow    = flags_q.overflow;
  assign underflow   = flags_q.underflow;
  assign div_by_zero = flags_q.div_by_zero;
  assign invalid     = flags_q.invalid;

endmodule

// File: tb/tb_fp32_div_seq.sv
// tb/tb_fp32_div_seq.sv - directed vector bench for fp32_div_seq
// Expected 1/3 and 2/3 results follow FP_DIV_ROUND_EN.
module tb_fp32_div_seq;

  localparam int BPC      = 1;
  localparam int N_ITER   = 26 / BPC;
  localparam int LAT_NORM = 2 + N_ITER;
  localparam int LAT_SPEC = 2;

`ifdef FP_DIV_ROUND_EN
  localparam logic [31:0] R13 = 32'h3EAAAAAB;
  localparam logic [31:0] R23 = 32'h3F2AAAAB;
`else
  localparam logic [31:0] R13 = 32'h3EAAAAAA;
  localparam logic [31:0] R23 = 32'h3F2AAAAA;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data1;
  logic [31:0] data2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;
  logic        div_by_zero;
  logic        invalid;

  int n_cmp = 0;
  int n_err = 0;

  fp32_div_seq #(.BITS_PER_CYCLE(BPC)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .data1       (data1),
    .data2       (data2),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .overflow    (overflow),
    .underflow   (underflow),
    .div_by_zero (div_by_zero),
    .invalid     (invalid)
  );

  always #5 clk = ~clk;

  // flg order: {invalid, div_by_zero, overflow, underflow}
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  flg;
    logic        norm;
  } vec_t;

  vec_t vecs [21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called just after the accept edge; returns posedges until out_valid.
  task automatic wait_done(output int lat);
    lat = 0;
    while (lat < 100) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid) break;
      @(posedge clk);
      lat++;
    end
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic consume,
                       output logic [31:0] res, output logic [3:0] flg, output int lat);
    @(negedge clk);
    in_valid = 1'b1;
    data1    = a;
    data2    = b;
    @(posedge clk);
    wait_done(lat);
    res = result;
    flg = {invalid, div_by_zero, overflow, underflow};
    if (consume) begin
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] res;
    logic [3:0]  flg;
    int          lat;

    vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 1'b1};
    vecs[1]  = '{32'h3F800000, 32'h40400000, R13,          4'b0000, 1'b1};
    vecs[2]  = '{32'h40000000, 32'h40400000, R23,          4'b0000, 1'b1};
    vecs[3]  = '{32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0100, 1'b0};
    vecs[4]  = '{32'h00000000, 32'h80000000, 32'h7FC00000, 4'b1000, 1'b0};
    vecs[5]  = '{32'h7F000000, 32'h3E800000, 32'h7F800000, 4'b0010, 1'b1};
    vecs[6]  = '{32'h80800000, 32'h40000000, 32'h80000000, 4'b0001, 1'b1};
    vecs[7]  = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'b1000, 1'b0};
    vecs[8]  = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 4'b1000, 1'b0};
    vecs[9]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, 1'b0};
    vecs[10] = '{32'h40000000, 32'h7F800000, 32'h00000000, 4'b0000, 1'b0};
    vecs[11] = '{32'h00400000, 32'h3F800000, 32'h00000000, 4'b0000, 1'b0};
    vecs[12] = '{32'h3F800000, 32'h80400000, 32'hFF800000, 4'b0100, 1'b0};
    vecs[13] = '{32'hC0000000, 32'h3F800000, 32'hC0000000, 4'b0000, 1'b1};
    vecs[14] = '{32'h3FC00000, 32'h3F000000, 32'h40400000, 4'b0000, 1'b1};
    vecs[15] = '{32'h3F800000, 32'h3F800001, 32'h3F7FFFFE, 4'b0000, 1'b1};
    vecs[16] = '{32'h7F000000, 32'h3F800000, 32'h7F000000, 4'b0000, 1'b1};
    vecs[17] = '{32'h00800000, 32'h3F800000, 32'h00800000, 4'b0000, 1'b1};
    vecs[18] = '{32'h3F800000, 32'h7F000000, 32'h00000000, 4'b0001, 1'b1};
    vecs[19] = '{32'h7F800000, 32'h00000000, 32'h7F800000, 4'b0000, 1'b0};
    vecs[20] = '{32'h00000000, 32'h7FC00001, 32'h7FC00000, 4'b1000, 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    data1     = '0;
    data2     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset result", result, 32'h0);
    check("reset flags", 32'({invalid, div_by_zero, overflow, underflow}), 32'd0);

    for (int i = 0; i < 21; i++) begin
      do_op(vecs[i].a, vecs[i].b, 1'b1, res, flg, lat);
      check($sformatf("v%0d result", i), res, vecs[i].res);
      check($sformatf("v%0d flags", i), 32'(flg), 32'(vecs[i].flg));
      check($sformatf("v%0d latency", i), 32'(lat), vecs[i].norm ? 32'(LAT_NORM) : 32'(LAT_SPEC));
    end

    // Hold DONE with out_ready low while a new operand is offered.
    do_op(32'h40C00000, 32'h40000000, 1'b0, res, flg, lat);
    check("hold first result", res, 32'h40400000);
    in_valid = 1'b1;
    data1    = 32'h3F800000;
    data2    = 32'h40400000;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("hold%0d result", i), result, 32'h40400000);
      check($sformatf("hold%0d flags", i), 32'({invalid, div_by_zero, overflow, underflow}), 32'd0);
      check($sformatf("hold%0d out_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("hold%0d in_ready", i), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("release in_ready", 32'(in_ready), 32'd1);
    check("release out_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
    @(posedge clk);
    wait_done(lat);
    check("post-hold result", result, R13);
    check("post-hold latency", 32'(lat), 32'(LAT_NORM));
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;

    // Abort mid-DIVIDE with rst.
    in_valid = 1'b1;
    data1    = 32'h40C00000;
    data2    = 32'h40000000;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("busy in_ready", 32'(in_ready), 32'd0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("mid-divide out_valid", 32'(out_valid), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort in_ready", 32'(in_ready), 32'd1);
    check("abort out_valid", 32'(out_valid), 32'd0);
    check("abort result", result, 32'h0);
    do_op(32'h40C00000, 32'h40000000, 1'b1, res, flg, lat);
    check("after abort result", res, 32'h40400000);
    check("after abort flags", 32'(flg), 32'd0);
    check("after abort latency", 32'(lat), 32'(LAT_NORM));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
